// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg7_pkg;

  localparam int DP_BIT = 7;

  // Latched per-digit content. It is captured on iLOAD and shown from the next frame.
  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
    logic       blank;
  } digit_t;

  function automatic int dwell_cycles(input int clk_freq, input int scan_hz);
    return clk_freq / scan_hz;
  endfunction

  // Active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = hex2seg(i_nib);
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver. It provides guard time, PWM dimming,
// leading-zero suppression and frame-synchronous value loading.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_FREQ       = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int GUARD_CYC      = 16,
  parameter int DIM_BITS       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int COM_ACTIVE_LOW = 1
)(
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [4*NUM_DIGITS-1:0] iDIG,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic [NUM_DIGITS-1:0]   iBLANK,
  input  logic                    iLZS,
  input  logic                    iLOAD,
  input  logic [DIM_BITS-1:0]     iBRIGHT,
  output logic [7:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oCOM,
  output logic                    oFRAME
);
  localparam int DWELL = dwell_cycles(CLK_FREQ, SCAN_HZ);
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] COM_OFF = (COM_ACTIVE_LOW != 0) ? '1 : '0;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
      $error("seg7_scan_driver: NUM_DIGITS must be in 1..16");
    end
    if (DWELL < 2 * (1 << DIM_BITS)) begin : g_bad_dwell
      $error("seg7_scan_driver: DWELL must be at least 2*2^DIM_BITS");
    end
    if (GUARD_CYC >= DWELL) begin : g_bad_guard
      $error("seg7_scan_driver: GUARD_CYC must be below DWELL");
    end
  endgenerate

  logic [DW_W-1:0]     r_dwell;
  logic [IX_W-1:0]     r_idx;
  logic [DIM_BITS-1:0] r_pwm;
  digit_t [NUM_DIGITS-1:0] r_pend, r_act;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_com;
  logic                  r_frame;

  digit_t [NUM_DIGITS-1:0]      w_in;
  logic [NUM_DIGITS-1:0][7:0]   w_pat;
  logic [NUM_DIGITS:0]          w_zero_up;   // [k]: nibbles k..N-1 are all zero
  logic [NUM_DIGITS-1:0]        w_sel;
  logic [7:0]                   w_cur;
  logic w_last_dw, w_wrap, w_pwm_ok, w_en;

  assign w_zero_up[NUM_DIGITS] = 1'b1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    logic [6:0] w_seg7;
    logic       w_sup;

    assign w_in[k].nib   = iDIG[4*k +: 4];
    assign w_in[k].dp    = iDP[k];
    assign w_in[k].blank = iBLANK[k];

    seg7_hex_decode u_dec (
      .i_nib (r_act[k].nib),
      .o_seg (w_seg7)
    );

    assign w_zero_up[k] = w_zero_up[k+1] & (r_act[k].nib == 4'h0);
    assign w_sup        = iLZS & (k > 0) & w_zero_up[k];

    // Suppression darkens a..g only; blanking also kills the DP.
    assign w_pat[k][DP_BIT] = r_act[k].dp & ~r_act[k].blank;
    assign w_pat[k][6:0]    = (r_act[k].blank | w_sup) ? 7'h00 : w_seg7;
  end

  always_comb begin
    w_sel        = '0;
    w_sel[r_idx] = 1'b1;
  end

  assign w_cur     = w_pat[r_idx];
  assign w_last_dw = (r_dwell == DW_W'(DWELL - 1));
  assign w_wrap    = w_last_dw && (r_idx == IX_W'(NUM_DIGITS - 1));
  assign w_pwm_ok  = (r_pwm < iBRIGHT) || (&iBRIGHT);
  assign w_en      = (r_dwell >= DW_W'(GUARD_CYC)) && w_pwm_ok && !r_act[r_idx].blank;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_dwell <= '0;
      r_idx   <= '0;
      r_pwm   <= '0;
      r_pend  <= '0;
      r_act   <= '0;
      r_seg   <= SEG_OFF;
      r_com   <= COM_OFF;
      r_frame <= 1'b0;
    end else begin
      r_pwm   <= r_pwm + 1'b1;
      r_dwell <= w_last_dw ? '0 : r_dwell + 1'b1;
      if (w_last_dw)
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      if (iLOAD)
        r_pend <= w_in;
      // A load that coincides with the wrap bypasses pending so it is not lost for a frame.
      if (w_wrap)
        r_act <= iLOAD ? w_in : r_pend;
      r_frame <= w_wrap;
      r_seg   <= (SEG_ACTIVE_LOW != 0) ? ~w_cur : w_cur;
      r_com   <= w_en ? ((COM_ACTIVE_LOW != 0) ? ~w_sel : w_sel) : COM_OFF;
    end
  end

  assign oSEG   = r_seg;
  assign oCOM   = r_com;
  assign oFRAME = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver. It uses 4 digits, DWELL=16, GUARD=2,
// DIM_BITS=2, and active-low segments and COMs.
module tb_seg7_scan_driver;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [15:0] iDIG = '0;
  logic [3:0]  iDP = '0, iBLANK = '0;
  logic        iLZS = 1'b0, iLOAD = 1'b0;
  logic [1:0]  iBRIGHT = 2'b11;
  logic [7:0]  oSEG;
  logic [3:0]  oCOM;
  logic        oFRAME;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .CLK_FREQ(1600), .SCAN_HZ(100), .GUARD_CYC(2),
    .DIM_BITS(2), .SEG_ACTIVE_LOW(1), .COM_ACTIVE_LOW(1)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDIG(iDIG), .iDP(iDP), .iBLANK(iBLANK),
    .iLZS(iLZS), .iLOAD(iLOAD), .iBRIGHT(iBRIGHT),
    .oSEG(oSEG), .oCOM(oCOM), .oFRAME(oFRAME)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [15:0]     dig;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lzs;
    logic [1:0]      bright;
    logic [3:0][7:0] seg;   // expected oSEG per digit, mid-dwell
    logic [3:0][4:0] on;    // expected COM-active cycles per digit
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vt [8];
  logic [7:0] cs [64];
  logic [3:0] cc [64];
  logic       cf [64];

  function automatic vec_t mk(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] bl,
                              input logic lz, input logic [1:0] br,
                              input logic [31:0] sg, input logic [19:0] on);
    return {dg, dp, bl, lz, br, sg, on};
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!oFRAME && n < 200);
    chk("frame_sync", {31'd0, oFRAME}, 32'd1);
  endtask

  // Starts just after an oFRAME sample. Sample p reflects digit p/16 at dwell p%16.
  task automatic run_frame(input int load_at, input logic [15:0] d,
                           input logic [3:0] dp, input logic [3:0] bl);
    for (int p = 0; p < 64; p++) begin
      if (p == load_at) begin
        iDIG = d; iDP = dp; iBLANK = bl; iLOAD = 1'b1;
      end
      tick();
      iLOAD = 1'b0;
      cs[p] = oSEG; cc[p] = oCOM; cf[p] = oFRAME;
    end
  endtask

  task automatic check_frame(input vec_t v, input int i);
    int on_cnt, stray, nfrm;
    logic [3:0] oh;
    stray = 0;
    nfrm  = 0;
    for (int d = 0; d < 4; d++) begin
      oh = ~(4'b0001 << d);
      on_cnt = 0;
      for (int j = 0; j < 16; j++) begin
        if (cc[d*16+j] === oh) on_cnt++;
        else if (cc[d*16+j] !== 4'hF) stray++;
      end
      chk($sformatf("v%0d_seg%0d", i, d), {24'd0, cs[d*16+8]}, {24'd0, v.seg[d]});
      chk($sformatf("v%0d_on%0d", i, d), on_cnt, {27'd0, v.on[d]});
    end
    for (int p = 0; p < 64; p++) if (cf[p]) nfrm++;
    chk($sformatf("v%0d_com_stray", i), stray, 0);
    chk($sformatf("v%0d_frame_period", i), {nfrm[30:0], cf[63]}, {31'd1, 1'b1});
  endtask

  task automatic reset_and_release(input string tag);
    iRST = 1'b1;
    repeat (3) tick();
    chk({tag, "_rst_com"}, {28'd0, oCOM}, 32'hF);
    chk({tag, "_rst_seg"}, {24'd0, oSEG}, 32'hFF);
    chk({tag, "_rst_frame"}, {31'd0, oFRAME}, 32'd0);
    iRST = 1'b0;
    tick();
    chk({tag, "_guard0"}, {28'd0, oCOM}, 32'hF);
    tick();
    chk({tag, "_guard1"}, {28'd0, oCOM}, 32'hF);
    tick();
    chk({tag, "_first_com"}, {28'd0, oCOM}, 32'hE);
    chk({tag, "_first_seg"}, {24'd0, oSEG}, 32'hC0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(16'h12AF, 4'b0010, 4'b0000, 1'b0, 2'd3, 32'hF9A4088E, {4{5'd14}});
    vt[1] = mk(16'h0040, 4'b0000, 4'b0000, 1'b1, 2'd3, 32'hFFFF99C0, {4{5'd14}});
    vt[2] = mk(16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3, 32'hFFFFFFC0, {4{5'd14}});
    vt[3] = mk(16'h12AF, 4'b0000, 4'b0000, 1'b0, 2'd1, 32'hF9A4888E, {4{5'd3}});
    vt[4] = mk(16'h12AF, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'hF9A4888E, 20'd0);
    vt[5] = mk(16'h12AF, 4'b0100, 4'b0100, 1'b0, 2'd3, 32'hF9FF888E,
               {5'd14, 5'd0, 5'd14, 5'd14});
    vt[6] = mk(16'h12AF, 4'b0000, 4'b0000, 1'b0, 2'd2, 32'hF9A4888E, {4{5'd6}});
    vt[7] = mk(16'h0A05, 4'b1000, 4'b0000, 1'b1, 2'd3, 32'h7F88C092, {4{5'd14}});

    reset_and_release("init");
    wait_frame();

    for (int i = 0; i < 8; i++) begin
      iLZS = vt[i].lzs;
      iBRIGHT = vt[i].bright;
      run_frame(5, vt[i].dig, vt[i].dp, vt[i].blank);
      run_frame(-1, 16'h0, 4'h0, 4'h0);
      check_frame(vt[i], i);
    end

    // A load in mid-frame must wait for the wrap.
    iLZS = 1'b0;
    iBRIGHT = 2'b11;
    run_frame(5, 16'h12AF, 4'h0, 4'h0);
    run_frame(20, 16'h0000, 4'h0, 4'h0);
    chk("tear_d0_old", {24'd0, cs[8]},  32'h8E);
    chk("tear_d1_old", {24'd0, cs[24]}, 32'h88);
    chk("tear_d2_old", {24'd0, cs[40]}, 32'hA4);
    chk("tear_d3_old", {24'd0, cs[56]}, 32'hF9);
    run_frame(-1, 16'h0, 4'h0, 4'h0);
    chk("tear_d0_new", {24'd0, cs[8]},  32'hC0);
    chk("tear_d2_new", {24'd0, cs[40]}, 32'hC0);
    chk("tear_d3_new", {24'd0, cs[56]}, 32'hC0);

    // A load on the wrap cycle goes straight to the displayed value.
    run_frame(63, 16'h12AF, 4'h0, 4'h0);
    chk("wrapload_d3_old", {24'd0, cs[56]}, 32'hC0);
    chk("wrapload_frame", {31'd0, cf[63]}, 32'd1);
    run_frame(-1, 16'h0, 4'h0, 4'h0);
    chk("wrapload_d0_new", {24'd0, cs[8]},  32'h8E);
    chk("wrapload_d3_new", {24'd0, cs[56]}, 32'hF9);

    // Reset while digit 1 is being scanned.
    repeat (20) tick();
    reset_and_release("mid");
    wait_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
